os_systolic_matmul: RTL and testbench

- Output-stationary N x N systolic matrix multiplier computing C = A x B, with A being N x K and B being K x N.
- Successor to the fixed-size band-matrix array. It adds:
  - internal input skewing, so callers stream unskewed A columns and B rows;
  - a runtime inner dimension K;
  - valid/ready handshakes on all streams;
  - a control FSM;
  - row-serial result drain with backpressure.
- Sits between operand buffers and the result writeback path.

---
 rtl/os_systolic_matmul.sv | 248 ++++++++++++++++++++++++
 tb/tb_os_systolic_matmul.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/os_systolic_matmul.sv
`default_nettype none
// ============================================================================
// Module      : os_systolic_matmul
// Description : Output-stationary N x N systolic matrix multiplier, C = A x B,
//               with internal operand skew, runtime K and row-serial drain.
//               Optional macro OS_SYSTOLIC_MATMUL_SAT_EN: saturating accumulators.
// Revision    : 1.0 - initial release
// ============================================================================
module os_systolic_matmul #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24,
  parameter int K_MAX      = 256,
  parameter int SIGNED     = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [$clog2(K_MAX+1)-1:0]   k_len,
  output logic                         busy,
  input  logic                         a_valid,
  output logic                         a_ready,
  input  logic [N*DATA_WIDTH-1:0]      a_col,
  input  logic                         b_valid,
  output logic                         b_ready,
  input  logic [N*DATA_WIDTH-1:0]      b_row,
  output logic                         c_valid,
  input  logic                         c_ready,
  output logic [N*ACC_WIDTH-1:0]       c_row,
  output logic                         c_last,
  output logic                         done
);

  localparam int c_kw = $clog2(K_MAX+1);
  localparam int c_fw = $clog2(2*N);
  localparam int c_rw = (N > 1) ? $clog2(N) : 1;
  localparam int c_ew = (ACC_WIDTH > 2*DATA_WIDTH) ? ACC_WIDTH : 2*DATA_WIDTH;
  localparam logic [c_fw-1:0] c_flush_last = c_fw'(2*N-2);
  localparam logic [c_rw-1:0] c_row_last   = c_rw'(N-1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_FLUSH  = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [c_kw-1:0]   r_k;
  logic [c_kw-1:0]   r_beats;
  logic [c_fw-1:0]   r_flush_cnt;
  logic [c_rw-1:0]   r_row;
  logic              r_done;

  logic w_fire;
  logic w_start_ok;
  logic w_c_fire;
  logic w_last_beat;
  logic w_last_row;

  // Multiply-accumulate for one PE; product is extended per SIGNED before the add.
  function automatic logic [ACC_WIDTH-1:0] f_mac(input logic [ACC_WIDTH-1:0]  acc,
                                                 input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
    logic [2*DATA_WIDTH-1:0] prod;
    logic [c_ew-1:0]         prod_ext;
    logic [ACC_WIDTH-1:0]    p;
`ifdef OS_SYSTOLIC_MATMUL_SAT_EN
    logic [ACC_WIDTH:0]      sum;
`endif
    if (SIGNED != 0) begin
      prod     = $signed({{DATA_WIDTH{a[DATA_WIDTH-1]}}, a}) *
                 $signed({{DATA_WIDTH{b[DATA_WIDTH-1]}}, b});
      prod_ext = c_ew'($signed(prod));
    end else begin
      prod     = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};
      prod_ext = c_ew'(prod);
    end
    p = prod_ext[ACC_WIDTH-1:0];
`ifdef OS_SYSTOLIC_MATMUL_SAT_EN
    if (SIGNED != 0) begin
      sum = {acc[ACC_WIDTH-1], acc} + {p[ACC_WIDTH-1], p};
      if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1])
        f_mac = sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      else
        f_mac = sum[ACC_WIDTH-1:0];
    end else begin
      sum   = {1'b0, acc} + {1'b0, p};
      f_mac = sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
    end
`else
    f_mac = acc + p;
`endif
  endfunction

  assign w_start_ok  = (r_state == S_IDLE) && start;
  assign w_fire      = (r_state == S_STREAM) && a_valid && b_valid;
  assign w_c_fire    = c_valid && c_ready;
  assign w_last_beat = ((r_beats + c_kw'(1)) == r_k);
  assign w_last_row  = (r_row == c_row_last);

  assign busy    = (r_state != S_IDLE);
  assign a_ready = (r_state == S_STREAM);
  assign b_ready = (r_state == S_STREAM);
  assign c_valid = (r_state == S_DRAIN) && !r_done;
  assign c_last  = c_valid && w_last_row;
  assign done    = r_done;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = (k_len == '0) ? S_FLUSH : S_STREAM;
      S_STREAM: if (w_fire && w_last_beat) w_state_nxt = S_FLUSH;
      S_FLUSH:  if (r_flush_cnt == c_flush_last) w_state_nxt = S_DRAIN;
      S_DRAIN:  if (r_done) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_beats     <= '0;
      r_flush_cnt <= '0;
      r_row       <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // done fires in the cycle after the final row handshake, while still in DRAIN
      r_done  <= w_c_fire && w_last_row;
      if (w_start_ok) begin
        r_k         <= k_len;
        r_beats     <= '0;
        r_flush_cnt <= '0;
        r_row       <= '0;
      end
      if (w_fire)
        r_beats <= r_beats + c_kw'(1);
      if (r_state == S_FLUSH)
        r_flush_cnt <= r_flush_cnt + c_fw'(1);
      if (w_c_fire && !w_last_row)
        r_row <= r_row + c_rw'(1);
    end
  end

  // Skewed operands entering the left column / top row of the array.
  logic [DATA_WIDTH-1:0] w_a_edge  [N];
  logic                  w_av_edge [N];
  logic [DATA_WIDTH-1:0] w_b_edge  [N];
  logic                  w_bv_edge [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_skew
    if (gi == 0) begin : g_direct
      assign w_a_edge[gi]  = a_col[gi*DATA_WIDTH +: DATA_WIDTH];
      assign w_av_edge[gi] = w_fire;
      assign w_b_edge[gi]  = b_row[gi*DATA_WIDTH +: DATA_WIDTH];
      assign w_bv_edge[gi] = w_fire;
    end else begin : g_delay
      logic [DATA_WIDTH-1:0] r_a_sh  [gi];
      logic                  r_av_sh [gi];
      logic [DATA_WIDTH-1:0] r_b_sh  [gi];
      logic                  r_bv_sh [gi];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int s = 0; s < gi; s++) begin
            r_a_sh[s]  <= '0;
            r_av_sh[s] <= 1'b0;
            r_b_sh[s]  <= '0;
            r_bv_sh[s] <= 1'b0;
          end
        end else begin
          r_a_sh[0]  <= a_col[gi*DATA_WIDTH +: DATA_WIDTH];
          r_av_sh[0] <= w_fire;
          r_b_sh[0]  <= b_row[gi*DATA_WIDTH +: DATA_WIDTH];
          r_bv_sh[0] <= w_fire;
          for (int s = 1; s < gi; s++) begin
            r_a_sh[s]  <= r_a_sh[s-1];
            r_av_sh[s] <= r_av_sh[s-1];
            r_b_sh[s]  <= r_b_sh[s-1];
            r_bv_sh[s] <= r_bv_sh[s-1];
          end
        end
      end
      assign w_a_edge[gi]  = r_a_sh[gi-1];
      assign w_av_edge[gi] = r_av_sh[gi-1];
      assign w_b_edge[gi]  = r_b_sh[gi-1];
      assign w_bv_edge[gi] = r_bv_sh[gi-1];
    end
  end

  logic [DATA_WIDTH-1:0] r_a   [N][N];
  logic                  r_av  [N][N];
  logic [DATA_WIDTH-1:0] r_b   [N][N];
  logic                  r_bv  [N][N];
  logic [ACC_WIDTH-1:0]  r_acc [N][N];

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      logic [DATA_WIDTH-1:0] w_a_in;
      logic                  w_av_in;
      logic [DATA_WIDTH-1:0] w_b_in;
      logic                  w_bv_in;

      if (gj == 0) begin : g_a_edge
        assign w_a_in  = w_a_edge[gi];
        assign w_av_in = w_av_edge[gi];
      end else begin : g_a_link
        assign w_a_in  = r_a[gi][gj-1];
        assign w_av_in = r_av[gi][gj-1];
      end

      if (gi == 0) begin : g_b_edge
        assign w_b_in  = w_b_edge[gj];
        assign w_bv_in = w_bv_edge[gj];
      end else begin : g_b_link
        assign w_b_in  = r_b[gi-1][gj];
        assign w_bv_in = r_bv[gi-1][gj];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a[gi][gj]   <= '0;
          r_av[gi][gj]  <= 1'b0;
          r_b[gi][gj]   <= '0;
          r_bv[gi][gj]  <= 1'b0;
          r_acc[gi][gj] <= '0;
        end else begin
          r_a[gi][gj]  <= w_a_in;
          r_av[gi][gj] <= w_av_in;
          r_b[gi][gj]  <= w_b_in;
          r_bv[gi][gj] <= w_bv_in;
          if (w_start_ok)
            r_acc[gi][gj] <= '0;
          else if (w_av_in && w_bv_in)
            r_acc[gi][gj] <= f_mac(r_acc[gi][gj], w_a_in, w_b_in);
        end
      end
    end
  end

  for (genvar gj = 0; gj < N; gj++) begin : g_out
    assign c_row[gj*ACC_WIDTH +: ACC_WIDTH] = c_valid ? r_acc[r_row][gj] : '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_os_systolic_matmul.sv
`default_nettype none
// ============================================================================
// Module      : tb_os_systolic_matmul
// Description : Directed self-checking bench for os_systolic_matmul (signed,
//               unsigned and 16-bit accumulator instances driven in lockstep).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_os_systolic_matmul;
  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int AW  = 24;
  localparam int AWO = 16;
  localparam int KW  = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start, a_valid, b_valid, c_ready;
  logic [KW-1:0] k_len;
  logic [N*DW-1:0] a_col, b_row;

  logic busy, a_ready, b_ready, c_valid, c_last, done;
  logic [N*AW-1:0] c_row;
  logic busy_u, a_ready_u, b_ready_u, c_valid_u, c_last_u, done_u;
  logic [N*AW-1:0] c_row_u;
  logic busy_o, a_ready_o, b_ready_o, c_valid_o, c_last_o, done_o;
  logic [N*AWO-1:0] c_row_o;

  os_systolic_matmul #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .K_MAX(256), .SIGNED(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .busy(busy),
    .a_valid(a_valid), .a_ready(a_ready), .a_col(a_col),
    .b_valid(b_valid), .b_ready(b_ready), .b_row(b_row),
    .c_valid(c_valid), .c_ready(c_ready), .c_row(c_row), .c_last(c_last), .done(done));

  os_systolic_matmul #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .K_MAX(256), .SIGNED(0)) dut_u (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .busy(busy_u),
    .a_valid(a_valid), .a_ready(a_ready_u), .a_col(a_col),
    .b_valid(b_valid), .b_ready(b_ready_u), .b_row(b_row),
    .c_valid(c_valid_u), .c_ready(c_ready), .c_row(c_row_u), .c_last(c_last_u), .done(done_u));

  os_systolic_matmul #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AWO), .K_MAX(256), .SIGNED(1)) dut_o (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .busy(busy_o),
    .a_valid(a_valid), .a_ready(a_ready_o), .a_col(a_col),
    .b_valid(b_valid), .b_ready(b_ready_o), .b_row(b_row),
    .c_valid(c_valid_o), .c_ready(c_ready), .c_row(c_row_o), .c_last(c_last_o), .done(done_o));

  int n_cmp = 0;
  int n_err = 0;

  logic signed [DW-1:0] A [N][8];
  logic signed [DW-1:0] B [8][N];
  logic [AW-1:0]  got   [N][N];
  logic [AW-1:0]  got_u [N][N];
  logic [AWO-1:0] got_o [N][N];
  time hs_t, cv_t;

  task automatic check(input string tag, input logic [N*AW-1:0] obs, input logic [N*AW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] gold(input int i, input int j, input int k);
    int s = 0;
    for (int kk = 0; kk < k; kk++) s += int'(A[i][kk]) * int'(B[kk][j]);
    return AW'(s);
  endfunction

  task automatic drive_beat(input int k);
    for (int l = 0; l < N; l++) begin
      a_col[l*DW +: DW] = A[l][k];
      b_row[l*DW +: DW] = B[k][l];
    end
  endtask

  // Called and returns on a falling edge.
  task automatic run_job(input int k, input bit gaps, input int stall_row, input bit poke);
    int beats, guard, row, stall;
    bit fire, rd, first;
    logic [N*AW-1:0]  held, snap, snap_u;
    logic [N*AWO-1:0] snap_o;
    start = 1'b1; k_len = KW'(k);
    @(negedge clk); start = 1'b0;
    beats = 0; guard = 0;
    while (beats < k && guard < 400) begin
      a_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      b_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      drive_beat(beats);
      fire = a_valid && b_valid && a_ready;
      @(posedge clk);
      if (fire) begin beats++; hs_t = $time; end
      @(negedge clk); guard++;
    end
    a_valid = 1'b0; b_valid = 1'b0;
    check("beats", beats, k);
    check("ready_drop", {a_ready, b_ready}, 0);
    row = 0; guard = 0; first = 1'b1; stall = 0; held = '0;
    snap = '0; snap_u = '0; snap_o = '0;
    while (row < N && guard < 200) begin
      start = 1'b0; rd = 1'b0;
      if (c_valid) begin
        if (first) begin cv_t = $time; first = 1'b0; start = poke; end
        if (row == stall_row && stall < 5) begin
          if (stall == 0) held = c_row;
          else check("stall_stable", c_row, held);
          stall++; c_ready = 1'b0;
        end else c_ready = 1'b1;
        check("c_last", c_last, (row == N-1));
        rd = c_ready; snap = c_row; snap_u = c_row_u; snap_o = c_row_o;
      end else c_ready = 1'b0;
      @(posedge clk);
      if (rd) begin
        for (int j = 0; j < N; j++) begin
          got[row][j]   = snap[j*AW +: AW];
          got_u[row][j] = snap_u[j*AW +: AW];
          got_o[row][j] = snap_o[j*AWO +: AWO];
        end
        row++;
      end
      @(negedge clk); guard++;
    end
    c_ready = 1'b0;
    check("rows", row, N);
    // edges from the final input handshake to the edge that first samples c_valid
    if (k > 0) check("latency", (cv_t + 5 - hs_t) / 10, 2*N);
    check("done_pulse", done, 1);
    check("cvalid_drop", c_valid, 0);
    check("busy_in_done", busy, 1);
    start = poke;
    @(negedge clk); start = 1'b0;
    check("done_once", done, 0);
    check("idle", busy, 0);
    @(negedge clk);
    check("no_restart", busy, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a_valid = 1'b0; b_valid = 1'b0; c_ready = 1'b0;
    k_len = '0; a_col = '0; b_row = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_ready", {a_ready, b_ready}, 0);
    check("rst_cvalid", {c_valid, c_last, done}, 0);
    check("rst_crow", c_row, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // identity A, B rows 1..16
    for (int i = 0; i < N; i++) for (int k = 0; k < 8; k++) A[i][k] = (i == k) ? 8'sd1 : 8'sd0;
    for (int k = 0; k < 8; k++) for (int j = 0; j < N; j++) B[k][j] = 8'(4*k + j + 1);
    run_job(4, 1'b0, -1, 1'b0);
    for (int r = 0; r < N; r++) for (int j = 0; j < N; j++)
      check($sformatf("ident_c%0d%0d", r, j), got[r][j], AW'(4*r + j + 1));

    // sign handling, K=1
    for (int i = 0; i < N; i++) A[i][0] = -8'sd1;
    for (int j = 0; j < N; j++) B[0][j] = 8'sd2;
    run_job(1, 1'b0, -1, 1'b0);
    for (int r = 0; r < N; r++) for (int j = 0; j < N; j++) begin
      check($sformatf("signed_c%0d%0d", r, j), got[r][j], 24'hFFFFFE);
      check($sformatf("unsigned_c%0d%0d", r, j), got_u[r][j], 24'd510);
    end

    // bubbles, K=8, random gaps on both sides
    for (int i = 0; i < N; i++) for (int k = 0; k < 8; k++) A[i][k] = 8'(((i*3 + k*5) % 7) - 3);
    for (int k = 0; k < 8; k++) for (int j = 0; j < N; j++) B[k][j] = 8'(((k + 2*j) % 5) - 2);
    run_job(8, 1'b1, -1, 1'b0);
    for (int r = 0; r < N; r++) for (int j = 0; j < N; j++)
      check($sformatf("bubble_c%0d%0d", r, j), got[r][j], gold(r, j, 8));

    // backpressure on row 1 plus start pulses during DRAIN and the done cycle
    for (int i = 0; i < N; i++) for (int k = 0; k < 8; k++) A[i][k] = (i == k) ? 8'sd1 : 8'sd0;
    for (int k = 0; k < 8; k++) for (int j = 0; j < N; j++) B[k][j] = 8'(4*k + j + 1);
    run_job(4, 1'b0, 1, 1'b1);
    for (int r = 0; r < N; r++) for (int j = 0; j < N; j++)
      check($sformatf("bp_c%0d%0d", r, j), got[r][j], AW'(4*r + j + 1));

    // overflow: 4 x 127 x 127 = 64516
    for (int i = 0; i < N; i++) for (int k = 0; k < 8; k++) A[i][k] = 8'sd127;
    for (int k = 0; k < 8; k++) for (int j = 0; j < N; j++) B[k][j] = 8'sd127;
    run_job(4, 1'b0, -1, 1'b0);
    for (int r = 0; r < N; r++) for (int j = 0; j < N; j++) begin
`ifdef OS_SYSTOLIC_MATMUL_SAT_EN
      check($sformatf("ovf16_c%0d%0d", r, j), got_o[r][j], 16'h7FFF);
`else
      check($sformatf("ovf16_c%0d%0d", r, j), got_o[r][j], 16'hFC04);
`endif
      check($sformatf("ovf24_c%0d%0d", r, j), got[r][j], 24'd64516);
    end

    // reset in the middle of STREAM, then a fresh K=2 job
    start = 1'b1; k_len = KW'(4);
    @(negedge clk); start = 1'b0; a_valid = 1'b1; b_valid = 1'b1; drive_beat(0);
    @(negedge clk); drive_beat(1);
    @(negedge clk); a_valid = 1'b0; b_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_ready", a_ready, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < N; i++) for (int k = 0; k < 8; k++) A[i][k] = 8'(i + 1 + k);
    for (int k = 0; k < 8; k++) for (int j = 0; j < N; j++) B[k][j] = 8'(j - k);
    run_job(2, 1'b0, -1, 1'b0);
    for (int r = 0; r < N; r++) for (int j = 0; j < N; j++)
      check($sformatf("postrst_c%0d%0d", r, j), got[r][j], gold(r, j, 2));

    // k_len = 0 drains zeros
    for (int r = 0; r < N; r++) for (int j = 0; j < N; j++) got[r][j] = '1;
    run_job(0, 1'b0, -1, 1'b0);
    for (int r = 0; r < N; r++) for (int j = 0; j < N; j++)
      check($sformatf("k0_c%0d%0d", r, j), got[r][j], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
